// File: rtl/fft_stim_pkg.sv
// Shared types and constants for the FFT stimulus generator.
// Holds the pattern/FSM encodings, run configuration payload and LFSR step.
package fft_stim_pkg;

  localparam int unsigned FRAME_CNT_W = 16;
  localparam int unsigned GAP_CNT_W   = 8;

  // Galois taps for x^32 + x^22 + x^2 + x + 1 in right-shift form
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  typedef enum logic [1:0] {
    IMPULSE0 = 2'd0,
    IMPULSE1 = 2'd1,
    RECT     = 2'd2,
    RANDOM   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef struct packed {
    mode_e                  pat;
    logic [FRAME_CNT_W-1:0] frames;
  } run_cfg_t;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/fft_stim_gen_if.sv
// Sample stream between the stimulus generator and its consumer.
interface fft_stim_gen_if #(
  parameter int unsigned DATA_W = 16
) ();

  logic                     out_push;
  logic signed [DATA_W-1:0] out_real;
  logic signed [DATA_W-1:0] out_imag;
  logic                     out_last;
  logic                     out_stall;

  modport master (
    output out_push,
    output out_real,
    output out_imag,
    output out_last,
    input  out_stall
  );

  modport slave (
    input  out_push,
    input  out_real,
    input  out_imag,
    input  out_last,
    output out_stall
  );

endinterface

// File: rtl/fft_lfsr32.sv
// 32-bit Galois LFSR with synchronous seed load and single-step advance.
module fft_lfsr32
  import fft_stim_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        advance,
  output logic [31:0] state
);

  // load wins over advance so a run always begins from the seed
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SEED;
    end else if (load) begin
      state <= seed;
    end else if (advance) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/fft_stim_gen.sv
// FFT test-pattern generator: emits frames of impulse, rectangle or LFSR
// samples over a push/stall stream, with inter-frame gaps and run control.
module fft_stim_gen
  import fft_stim_pkg::*;
#(
  parameter int unsigned N_POINTS   = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned RECT_HALF  = 5,
  parameter int unsigned GAP_CYCLES = 1,
  parameter logic [31:0] LFSR_SEED  = 32'h0000_0001
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [1:0]             mode,
  input  logic [FRAME_CNT_W-1:0] num_frames,
  fft_stim_gen_if.master         ob,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned K_W = $clog2(N_POINTS);
  localparam logic [K_W-1:0]    K_LAST  = K_W'(N_POINTS - 1);
  localparam logic [K_W-1:0]    RECT_LO = K_W'(RECT_HALF);
  localparam logic [K_W-1:0]    RECT_HI = K_W'(N_POINTS - RECT_HALF);
  localparam logic [DATA_W-1:0] MAXV    = {1'b0, {(DATA_W-1){1'b1}}};

  state_e                 state;
  run_cfg_t               cfg;
  logic [K_W-1:0]         k;
  logic [GAP_CNT_W-1:0]   gap_cnt;
  logic                   push_q;
  logic                   last_q;
  logic [DATA_W-1:0]      smp_re_q;
  logic [DATA_W-1:0]      smp_im_q;
  logic [31:0]            lfsr_state;
  logic [31:0]            lfsr_stepped;
  logic [K_W-1:0]         k_inc;
  logic                   xfer;
  logic                   start_ok;

  // Sample value for pattern m at index k, given the LFSR state for that sample
  function automatic logic [2*DATA_W-1:0] gen_sample(input mode_e          m,
                                                     input logic [K_W-1:0] kk,
                                                     input logic [31:0]    s);
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
    re = '0;
    im = '0;
    case (m)
      IMPULSE0: if (kk == '0) re = MAXV;
      IMPULSE1: if (kk == K_W'(1)) re = MAXV;
      RECT:     if ((kk <= RECT_LO) || (kk >= RECT_HI)) re = MAXV;
      RANDOM: begin
        re = s[DATA_W-1:0];
        im = s[16+DATA_W-1:16];
      end
      default: re = '0;
    endcase
    return {im, re};
  endfunction

  assign xfer         = (state == RUN) && push_q && !ob.out_stall;
  assign start_ok     = (state == IDLE) && start && !abort;
  assign k_inc        = k + K_W'(1);
  assign lfsr_stepped = lfsr_next(lfsr_state);

  fft_lfsr32 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load    (start_ok),
    .seed    (LFSR_SEED),
    .advance (xfer),
    .state   (lfsr_state)
  );

  // Run-control FSM; stream registers only change on start, transfer or gap exit
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cfg      <= '0;
      k        <= '0;
      gap_cnt  <= '0;
      push_q   <= 1'b0;
      last_q   <= 1'b0;
      smp_re_q <= '0;
      smp_im_q <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            state                <= RUN;
            cfg                  <= '{pat: mode_e'(mode), frames: num_frames};
            k                    <= '0;
            {smp_im_q, smp_re_q} <= gen_sample(mode_e'(mode), '0, LFSR_SEED);
            push_q               <= 1'b1;
            last_q               <= 1'b0;
            busy                 <= 1'b1;
          end
        end

        RUN: begin
          if (abort) begin
            state    <= IDLE;
            k        <= '0;
            push_q   <= 1'b0;
            last_q   <= 1'b0;
            smp_re_q <= '0;
            smp_im_q <= '0;
            busy     <= 1'b0;
          end else if (xfer) begin
            k <= k_inc;
            if (k == K_LAST) begin
              // frames == 0 means continuous: never counts down, never finishes
              if (cfg.frames != '0) cfg.frames <= cfg.frames - 16'd1;
              if (cfg.frames == 16'd1) begin
                state    <= DONE;
                done     <= 1'b1;
                push_q   <= 1'b0;
                last_q   <= 1'b0;
                smp_re_q <= '0;
                smp_im_q <= '0;
              end else if (GAP_CYCLES == 0) begin
                {smp_im_q, smp_re_q} <= gen_sample(cfg.pat, k_inc, lfsr_stepped);
                last_q               <= 1'b0;
              end else begin
                state    <= GAP;
                gap_cnt  <= GAP_CNT_W'(GAP_CYCLES) - 8'd1;
                push_q   <= 1'b0;
                last_q   <= 1'b0;
                smp_re_q <= '0;
                smp_im_q <= '0;
              end
            end else begin
              {smp_im_q, smp_re_q} <= gen_sample(cfg.pat, k_inc, lfsr_stepped);
              last_q               <= (k_inc == K_LAST);
            end
          end
        end

        GAP: begin
          if (abort) begin
            state  <= IDLE;
            k      <= '0;
            busy   <= 1'b0;
          end else if (gap_cnt == '0) begin
            // LFSR already stepped on the previous frame's last transfer
            state                <= RUN;
            push_q               <= 1'b1;
            last_q               <= 1'b0;
            {smp_im_q, smp_re_q} <= gen_sample(cfg.pat, k, lfsr_state);
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          push_q <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

  assign ob.out_push = push_q;
  assign ob.out_real = smp_re_q;
  assign ob.out_imag = smp_im_q;
  assign ob.out_last = last_q;

endmodule
